// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that sequences operands one nibble per clock
// through a single 4-bit ripple-adder stage, with valid/ready on both sides.

module rippleadder_4bitd (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic            carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic            cout_r;
    logic            out_valid_r;
    logic            busy_r;
    logic            in_ready_r;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_sum;
    logic       nib_cout;

    assign nib_a = 4'(a_r >> (4 * idx));
    assign nib_b = 4'(b_r >> (4 * idx));

    rippleadder_4bitd u_stage (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_r),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // in_ready comes up on the first edge after reset so it reads 0 while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry_r     <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        carry_r    <= cin;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_r[4*idx +: 4] <= nib_sum;
                    carry_r           <= nib_cout;
                    if (idx == IDX_LAST) begin
                        idx         <= '0;
                        cout_r      <= nib_cout;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign busy      = busy_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16 and WIDTH=4, with a
// scoreboard queue filled on acceptance and drained on each result handshake.

module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        use4 = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic        in_ready16, out_valid16, cout16, busy16;
    logic [15:0] sum16;
    logic        in_ready4, out_valid4, cout4, busy4;
    logic [3:0]  sum4;
    logic        in_valid16, in_valid4, out_ready16, out_ready4;

    logic        in_ready_m, out_valid_m, cout_m, busy_m;
    logic [15:0] sum_m;

    typedef struct {
        logic [15:0] s;
        logic        c;
    } exp_t;

    exp_t exp_q[$];

    assign in_valid16  = in_valid  & ~use4;
    assign out_ready16 = out_ready & ~use4;
    assign in_valid4   = in_valid  &  use4;
    assign out_ready4  = out_ready &  use4;

    assign in_ready_m  = use4 ? in_ready4  : in_ready16;
    assign out_valid_m = use4 ? out_valid4 : out_valid16;
    assign cout_m      = use4 ? cout4      : cout16;
    assign busy_m      = use4 ? busy4      : busy16;
    assign sum_m       = use4 ? {12'h000, sum4} : sum16;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .busy(busy16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        logic [4:0]  t4;
        exp_t        e;
        if (use4) begin
            t4  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0, c};
            e.s = {12'h000, t4[3:0]};
            e.c = t4[4];
        end else begin
            t   = {1'b0, x} + {1'b0, y} + {16'b0, c};
            e.s = t[15:0];
            e.c = t[16];
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the acceptance edge with in_valid dropped again.
    task automatic apply_stimulus(input logic [15:0] na, input logic [15:0] nb, input logic nc);
        int k = 0;
        while (!in_ready_m && k < 20) begin
            step();
            k++;
        end
        check("in_ready_wait", 32'(in_ready_m), 32'd1);
        a = na;
        b = nb;
        cin = nc;
        in_valid = 1'b1;
        exp_q.push_back(model(na, nb, nc));
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_output(input string tag, input int exp_lat);
        int   k = 0;
        exp_t e;
        while (!out_valid_m && k < 20) begin
            step();
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_out_valid"}, 32'(out_valid_m), 32'd1);
        e = exp_q.pop_front();
        check({tag, "_sum"}, 32'(sum_m), 32'(e.s));
        check({tag, "_cout"}, 32'(cout_m), 32'(e.c));
        check({tag, "_busy_done"}, 32'(busy_m), 32'd1);
        check({tag, "_in_ready_done"}, 32'(in_ready_m), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_out_valid_clr"}, 32'(out_valid_m), 32'd0);
        check({tag, "_in_ready_idle"}, 32'(in_ready_m), 32'd1);
        check({tag, "_busy_idle"}, 32'(busy_m), 32'd0);
    endtask

    initial begin
        int   acc_cyc[2];
        int   n_acc;
        int   n_res;
        int   k;
        logic fire_in;
        logic fire_out;
        logic saw_valid;
        exp_t e;

        step();
        step();
        check("rst_sum", 32'(sum16), 32'h0);
        check("rst_out_valid", 32'(out_valid16), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_in_ready_held", 32'(in_ready16), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready_released", 32'(in_ready16), 32'd1);

        // T1: full carry ripple across all four nibbles
        apply_stimulus(16'hFFFF, 16'h0001, 1'b0);
        check_output("t1", 4);

        // T2: carry-in consumed on the first nibble, no internal carries afterwards
        apply_stimulus(16'h1234, 16'h4321, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_carry_reg", 32'(dut16.carry_r), 32'd0);
        end
        check_output("t2", 1);

        // T3: backpressure in DONE
        apply_stimulus(16'hF00F, 16'h2FF1, 1'b1);
        k = 0;
        while (!out_valid_m && k < 20) begin
            step();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(out_valid_m), 32'd1);
            check("t3_hold_sum", 32'(sum_m), 32'(exp_q[0].s));
            check("t3_hold_cout", 32'(cout_m), 32'(exp_q[0].c));
            check("t3_hold_in_ready", 32'(in_ready_m), 32'd0);
            step();
        end
        check_output("t3", 0);

        // T4: reset after two nibbles abandons the operation
        apply_stimulus(16'h1111, 16'h2222, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t4_sum", 32'(sum16), 32'h0);
        check("t4_cout", 32'(cout16), 32'd0);
        check("t4_out_valid", 32'(out_valid16), 32'd0);
        check("t4_busy", 32'(busy16), 32'd0);
        check("t4_in_ready", 32'(in_ready16), 32'd0);
        exp_q.delete();
        #3;
        rst_n = 1'b1;
        step();
        check("t4_in_ready_released", 32'(in_ready16), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw_valid |= out_valid16;
            step();
        end
        check("t4_no_result", 32'(saw_valid), 32'd0);

        // T5: back-to-back with in_valid held and out_ready always high
        exp_q.push_back(model(16'h00FF, 16'h0001, 1'b0));
        exp_q.push_back(model(16'h8000, 16'h8000, 1'b0));
        a = 16'h00FF;
        b = 16'h0001;
        cin = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        n_acc = 0;
        n_res = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        for (int i = 0; i < 40 && n_res < 2; i++) begin
            fire_in  = in_valid && in_ready_m;
            fire_out = out_valid_m;
            if (fire_out) begin
                e = exp_q.pop_front();
                check("t5_sum", 32'(sum_m), 32'(e.s));
                check("t5_cout", 32'(cout_m), 32'(e.c));
            end
            step();
            if (fire_in && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    a = 16'h8000;
                    b = 16'h8000;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (fire_out) n_res++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t5_results", 32'(n_res), 32'd2);
        check("t5_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);

        // T6: WIDTH=4 instance, single RUN cycle
        use4 = 1'b1;
        step();
        apply_stimulus(16'h000F, 16'h000F, 1'b1);
        check_output("t6", 1);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            check_output("t6_rand", 1);
        end

        use4 = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            check_output("rand16", 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
